// File: rtl/operand_stream_generator_if.sv
// Operand stream bundle: a/b data with independent stb/ack handshakes.
// The master is the operand source; the slave is the consuming FPU operator.
interface operand_stream_generator_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] output_a;
  logic             output_a_stb;
  logic             output_a_ack;
  logic [WIDTH-1:0] output_b;
  logic             output_b_stb;
  logic             output_b_ack;

  modport master (
    output output_a,
    output output_a_stb,
    input  output_a_ack,
    output output_b,
    output output_b_stb,
    input  output_b_ack
  );

  modport slave (
    input  output_a,
    input  output_a_stb,
    output output_a_ack,
    input  output_b,
    input  output_b_stb,
    output output_b_ack
  );
endinterface

// File: rtl/operand_stream_generator.sv
// LFSR-driven source of COUNT half-precision operand pairs on two stb/ack streams.
// Optional macro OPGEN_FINITE_ONLY_EN clamps Inf/NaN exponents and avoids a zero b operand.
module operand_stream_generator #(
  parameter int          WIDTH  = 16,
  parameter int          COUNT  = 256,
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h3C00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  operand_stream_generator_if.master   ops,
  output logic [15:0]                  sent_count,
  output logic                         done
);

  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == 16'h0000) ? WIDTH'(1) : WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == 16'h0000) ? WIDTH'(1) : WIDTH'(SEED_B);
  localparam logic [15:0]      COUNT_W    = 16'(COUNT);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ADVANCE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
  logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             stb_a_q, stb_a_d;
  logic             stb_b_q, stb_b_d;
  logic [15:0]      sent_q, sent_d;
  logic             done_q, done_d;

  // Fibonacci x^16+x^14+x^13+x^11+1
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

`ifdef OPGEN_FINITE_ONLY_EN
  function automatic logic [WIDTH-1:0] shape_a(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (r[14:10] == 5'b11111) r[14:10] = 5'b11110;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shape_b(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (r[14:10] == 5'b11111) r[14:10] = 5'b11110;
    if (r[14:0] == 15'd0) r[0] = 1'b1;
    return r;
  endfunction
`else
  function automatic logic [WIDTH-1:0] shape_a(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] shape_b(input logic [WIDTH-1:0] v);
    return v;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    stb_a_d  = stb_a_q;
    stb_b_d  = stb_b_q;
    sent_d   = sent_q;
    done_d   = done_q;

    case (state_q)
      IDLE: begin
        if (sent_q == COUNT_W) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (enable) begin
          out_a_d = shape_a(lfsr_a_q);
          out_b_d = shape_b(lfsr_b_q);
          stb_a_d = 1'b1;
          stb_b_d = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        if (stb_a_q && ops.output_a_ack) stb_a_d = 1'b0;
        if (stb_b_q && ops.output_b_ack) stb_b_d = 1'b0;
        // Leave on the edge of the last transfer so a pair costs 3 cycles with acks held.
        if (!stb_a_d && !stb_b_d) state_d = ADVANCE;
      end

      ADVANCE: begin
        lfsr_a_d = lfsr_next(lfsr_a_q);
        lfsr_b_d = lfsr_next(lfsr_b_q);
        if (sent_q != COUNT_W) sent_d = 16'(sent_q + 16'd1);
        state_d = IDLE;
      end

      DONE: begin
        stb_a_d = 1'b0;
        stb_b_d = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_a_q <= SEED_A_EFF;
      lfsr_b_q <= SEED_B_EFF;
      out_a_q  <= '0;
      out_b_q  <= '0;
      stb_a_q  <= 1'b0;
      stb_b_q  <= 1'b0;
      sent_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      stb_a_q  <= stb_a_d;
      stb_b_q  <= stb_b_d;
      sent_q   <= sent_d;
      done_q   <= done_d;
    end
  end

  assign ops.output_a     = out_a_q;
  assign ops.output_b     = out_b_q;
  assign ops.output_a_stb = stb_a_q;
  assign ops.output_b_stb = stb_b_q;
  assign sent_count       = sent_q;
  assign done             = done_q;

endmodule

// File: tb/tb_operand_stream_generator.sv
// Scoreboard bench: expected operand sequences are queued from a reference LFSR model
// and popped by per-DUT monitors on every observed stb/ack transfer.
module tb_operand_stream_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model
  function automatic logic [15:0] step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic logic [15:0] sfin(input logic [15:0] v, input bit is_b);
    logic [15:0] r;
    r = v;
`ifdef OPGEN_FINITE_ONLY_EN
    if (r[14:10] == 5'b11111) r[14:10] = 5'b11110;
    if (is_b && r[14:0] == 15'd0) r[0] = 1'b1;
`endif
    return r;
  endfunction

`ifdef OPGEN_FINITE_ONLY_EN
  localparam logic [15:0] EXP1_A = 16'h7800;
  localparam logic [15:0] EXP1_B = 16'h8001;
`else
  localparam logic [15:0] EXP1_A = 16'h7C00;
  localparam logic [15:0] EXP1_B = 16'h8000;
`endif

  // DUT0: defaults, randomized acks/enable, mid-run reset
  logic        rst0, en0, done0;
  logic [15:0] sc0;
  operand_stream_generator_if #(.WIDTH(16)) if0 ();
  operand_stream_generator #(.WIDTH(16)) dut0 (
    .clk(clk), .rst(rst0), .enable(en0), .ops(if0), .sent_count(sc0), .done(done0));

  // DUT1: COUNT=4, special seeds, acks held high
  logic        rst1, done1;
  logic [15:0] sc1;
  operand_stream_generator_if #(.WIDTH(16)) if1 ();
  operand_stream_generator #(.WIDTH(16), .COUNT(4), .SEED_A(16'h7C00), .SEED_B(16'h8000)) dut1 (
    .clk(clk), .rst(rst1), .enable(1'b1), .ops(if1), .sent_count(sc1), .done(done1));

  // DUT2: COUNT=0
  logic        done2;
  logic [15:0] sc2;
  operand_stream_generator_if #(.WIDTH(16)) if2 ();
  operand_stream_generator #(.WIDTH(16), .COUNT(0)) dut2 (
    .clk(clk), .rst(rst1), .enable(1'b1), .ops(if2), .sent_count(sc2), .done(done2));

  assign if1.output_a_ack = 1'b1;
  assign if1.output_b_ack = 1'b1;
  assign if2.output_a_ack = 1'b1;
  assign if2.output_b_ack = 1'b1;

  logic [15:0] q0a[$], q0b[$], q1a[$], q1b[$];
  int na = 0, nb = 0, n1a = 0, n1b = 0;
  int mode = 1;
  bit stb2_seen = 1'b0;

  task automatic load_queue(input logic [15:0] sa, input logic [15:0] sb, input int n, input bit which);
    logic [15:0] a, b;
    a = sa;
    b = sb;
    for (int i = 0; i < n; i++) begin
      if (which) begin q1a.push_back(sfin(a, 1'b0)); q1b.push_back(sfin(b, 1'b1)); end
      else       begin q0a.push_back(sfin(a, 1'b0)); q0b.push_back(sfin(b, 1'b1)); end
      a = step(a);
      b = step(b);
    end
  endtask

  // DUT0 ack/enable driver
  initial begin : drv0
    int wb;
    wb = 0;
    en0 = 1'b1;
    if0.output_a_ack = 1'b0;
    if0.output_b_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        en0 = 1'b1;
        if0.output_a_ack = 1'b1;
        wb = if0.output_b_stb ? wb + 1 : 0;
        if0.output_b_ack = (wb >= 5);
      end else begin
        en0 = ($urandom_range(0, 5) != 0);
        if0.output_a_ack = ($urandom_range(0, 1) == 1);
        if0.output_b_ack = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // DUT0 monitor
  logic        p_rst0 = 1'b0, p_en0 = 1'b0, p_sa = 1'b0, p_sb = 1'b0, p_aa = 1'b0, p_ab = 1'b0, p_done0 = 1'b0;
  logic [15:0] p_oa = '0, p_ob = '0;
  always @(negedge clk) begin
    int m;
    if (rst0 && p_rst0) begin
      if (if0.output_a_stb && !p_sa) begin
        check("a_rise_needs_enable", 32'(p_en0), 32'd1);
        check("b_rises_with_a", {30'd0, if0.output_b_stb, p_sb}, 32'd2);
      end
      if (p_sa && !p_aa) begin
        check("a_hold_stb", 32'(if0.output_a_stb), 32'd1);
        check("a_hold_data", 32'(if0.output_a), 32'(p_oa));
      end
      if (p_sb && !p_ab) begin
        check("b_hold_stb", 32'(if0.output_b_stb), 32'd1);
        check("b_hold_data", 32'(if0.output_b), 32'(p_ob));
      end
      m = (na < nb) ? na : nb;
      check("sent_le_pairs", 32'(int'(sc0) <= m), 32'd1);
      check("sent_ge_pairs_m1", 32'(int'(sc0) + 1 >= m), 32'd1);
      if (p_done0) check("done_sticky", 32'(done0), 32'd1);
      if (if0.output_a_stb && if0.output_a_ack) begin
        if (q0a.size() == 0) check("a_unexpected_transfer", 32'(na), 32'd256);
        else check("a_data", 32'(if0.output_a), 32'(q0a.pop_front()));
        na++;
      end
      if (if0.output_b_stb && if0.output_b_ack) begin
        if (q0b.size() == 0) check("b_unexpected_transfer", 32'(nb), 32'd256);
        else check("b_data", 32'(if0.output_b), 32'(q0b.pop_front()));
        nb++;
      end
    end
    p_rst0  = rst0;
    p_en0   = en0;
    p_sa    = if0.output_a_stb;
    p_sb    = if0.output_b_stb;
    p_aa    = if0.output_a_ack;
    p_ab    = if0.output_b_ack;
    p_oa    = if0.output_a;
    p_ob    = if0.output_b;
    p_done0 = done0;
  end

  // DUT1 / DUT2 monitor
  int          cyc = 0, last_rise = -1;
  logic        p_s1 = 1'b0;
  logic [15:0] p_sc1 = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst1) begin
      if (if2.output_a_stb || if2.output_b_stb) stb2_seen = 1'b1;
      check("dut1_sent_step", 32'(sc1 == p_sc1 || sc1 == 16'(p_sc1 + 16'd1)), 32'd1);
      if (if1.output_a_stb && !p_s1) begin
        if (last_rise >= 0) check("dut1_stb_period", 32'(cyc - last_rise), 32'd3);
        last_rise = cyc;
      end
      if (if1.output_a_stb) begin
        if (n1a == 0) check("dut1_first_a", 32'(if1.output_a), 32'(EXP1_A));
        if (q1a.size() == 0) check("dut1_a_extra", 32'(n1a), 32'd4);
        else check("dut1_a_data", 32'(if1.output_a), 32'(q1a.pop_front()));
        n1a++;
      end
      if (if1.output_b_stb) begin
        if (n1b == 0) check("dut1_first_b", 32'(if1.output_b), 32'(EXP1_B));
        if (q1b.size() == 0) check("dut1_b_extra", 32'(n1b), 32'd4);
        else check("dut1_b_data", 32'(if1.output_b), 32'(q1b.pop_front()));
        n1b++;
      end
    end
    p_s1  = if1.output_a_stb;
    p_sc1 = sc1;
  end

  initial begin : main
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_a", 32'(if0.output_a), 32'd0);
    check("rst_out_b", 32'(if0.output_b), 32'd0);
    check("rst_stb", {30'd0, if0.output_a_stb, if0.output_b_stb}, 32'd0);
    check("rst_sent", 32'(sc0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_done_dut1", 32'(done1), 32'd0);
    load_queue(16'hACE1, 16'h3C00, 256, 1'b0);
    load_queue(16'h7C00, 16'h8000, 4, 1'b1);
    check("model_second_a", 32'(q0a[1]), 32'(sfin(16'h59C3, 1'b0)));
    check("model_third_b", 32'(q0b[2]), 32'(sfin(16'hF002, 1'b1)));
    @(posedge clk);
    #2;
    rst0 = 1'b1;
    rst1 = 1'b1;

    // delayed-b phase, then randomized acks and enable
    for (int i = 0; i < 2000 && na < 6; i++) @(posedge clk);
    if (na < 6) check("delayed_phase_timeout", 32'(na), 32'd6);
    mode = 0;
    for (int i = 0; i < 5000 && na < 20; i++) @(posedge clk);
    if (na < 20) check("random_phase_timeout", 32'(na), 32'd20);
    for (int i = 0; i < 200 && !if0.output_a_stb; i++) @(posedge clk);
    if (!if0.output_a_stb) check("stb_wait_timeout", 32'(if0.output_a_stb), 32'd1);

    // asynchronous reset mid-transfer
    @(negedge clk);
    #2;
    rst0 = 1'b0;
    #1;
    check("rst_mid_stb_a", 32'(if0.output_a_stb), 32'd0);
    check("rst_mid_stb_b", 32'(if0.output_b_stb), 32'd0);
    q0a.delete();
    q0b.delete();
    load_queue(16'hACE1, 16'h3C00, 256, 1'b0);
    na = 0;
    nb = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mid_sent", 32'(sc0), 32'd0);
    rst0 = 1'b1;

    for (int i = 0; i < 20000 && !done0; i++) @(posedge clk);
    if (!done0) check("done_timeout", 32'(done0), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("final_sent", 32'(sc0), 32'd256);
    check("final_a_count", 32'(na), 32'd256);
    check("final_b_count", 32'(nb), 32'd256);
    check("final_queue_empty", 32'(q0a.size() + q0b.size()), 32'd0);
    check("final_done", 32'(done0), 32'd1);
    check("final_stb", {30'd0, if0.output_a_stb, if0.output_b_stb}, 32'd0);

    check("dut1_done", 32'(done1), 32'd1);
    check("dut1_sent", 32'(sc1), 32'd4);
    check("dut1_a_count", 32'(n1a), 32'd4);
    check("dut1_b_count", 32'(n1b), 32'd4);
    check("dut2_done", 32'(done2), 32'd1);
    check("dut2_sent", 32'(sc2), 32'd0);
    check("dut2_no_stb", 32'(stb2_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_stream_generator.md
Name: operand_stream_generator

Overview:
- Synthesizable stimulus source: produces COUNT pseudo-random 16-bit half-precision operand pairs from two LFSRs.
- Transmits them on two independent stb/ack output streams that feed the a/b operand inputs of an FPU operator (divider, multiplier, adder).
- Transmitting end of the operand interface; replaces file-based readers in self-contained hardware soak tests.

Parameters:
- WIDTH, 16, operand width in bits; the LFSR tap set below is defined for 16 only.
- COUNT, 256, number of operand pairs sent before done.
- SEED_A, 16'hACE1, initial LFSR state for stream a; 0 is replaced by 16'h0001.
- SEED_B, 16'h3C00, initial LFSR state for stream b; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new pair; sampled only in IDLE.
- output_a  out  WIDTH  operand a data.
- output_a_stb  out  1  operand a valid.
- output_a_ack  in  1  operand a accepted.
- output_b  out  WIDTH  operand b data.
- output_b_stb  out  1  operand b valid.
- output_b_ack  in  1  operand b accepted.
- sent_count  out  16  pairs fully transferred.
- done  out  1  COUNT pairs sent.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; lfsr_a=SEED_A, lfsr_b=SEED_B (zero seeds substituted).
  - output_a=0, output_b=0, both stb=0, sent_count=0, done=0.
  - Reset asserted mid-transfer drops stb immediately; the partial pair is discarded.
- LFSR step, Fibonacci x^16+x^14+x^13+x^11+1:
  - fb = q[15]^q[13]^q[12]^q[10].
  - next = {q[14:0], fb}.
- Transfer rule: a transfer occurs on a rising edge where stb=1 and ack=1.
  - stb clears on that edge.
  - Data and stb are registered and stay stable while stb=1 and ack=0.
- IDLE:
  - If sent_count==COUNT: go to DONE.
  - Else if enable=1: load output_a=S(lfsr_a) and output_b=S(lfsr_b), set both stb=1, go to SEND.
  - Else stay in IDLE.
  - S() is the identity unless the optional feature is enabled.
- SEND:
  - Each channel completes independently; the a and b acks may arrive in either order, the same cycle, or many cycles apart.
  - When both stb are 0, go to ADVANCE.
- ADVANCE:
  - Step both LFSRs once; sent_count += 1; go to IDLE.
- DONE:
  - done=1, both stb=0; held until reset; enable and ack are ignored.
- Throughput: with ack held high, one pair per 3 cycles.
  - Example: pair n stb rises at cycle k, transfers at k+1, pair n+1 stb rises at k+3.
- enable=0 during SEND/ADVANCE does not abort the pair; it only blocks the next IDLE start.
- COUNT=0: first IDLE cycle goes to DONE; no stb is ever raised.
- sent_count saturates at COUNT; it never wraps while COUNT < 65536.

Optional Feature:
- Macro: OPGEN_FINITE_ONLY_EN.
- Defined, S() on each operand:
  - Exponent field [14:10]==5'b11111 → replaced by 5'b11110 (no Inf/NaN sent).
  - Operand b only: if [14:0]==0 (±0), set bit 0 (no divide-by-zero).
  - Sign and other bits unchanged; the LFSR state itself is never modified.
- Undefined: S() is the identity; raw LFSR values are sent.

Test Plan:
- Defaults, enable=1, both acks held 1 → first pair a=16'hACE1, b=16'h3C00; second pair a=16'h59C3, b=16'h7801; third pair b=16'hF002; stb rises every 3 cycles.
- COUNT=4, acks held 1 → exactly 4 a-transfers and 4 b-transfers; sent_count steps 1..4; done=1 on the cycle after the ADVANCE that reaches 4, then stays 1; no further stb.
- ack_b delayed 5 cycles after ack_a → output_a_stb drops after its transfer; output_b and output_b_stb stay stable until ack_b; sent_count increments only after both transfers.
- enable toggled low during SEND → current pair completes; no new stb while enable=0 in IDLE; resumes with the next LFSR values when enable returns to 1.
- SEED_A=16'h7C00, SEED_B=16'h8000 → with OPGEN_FINITE_ONLY_EN: a=16'h7800, b=16'h8001. Without the macro: a=16'h7C00, b=16'h8000.
- rst pulsed low while output_a_stb=1 → stb=0 immediately; after release the first pair is again a=16'hACE1 (defaults) with sent_count=0.
